// File: rtl/cdc_pkg.sv
// Shared constants for the clock-1 output path: FSM encoding and default sizing.
package cdc_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_BURST_LEN = 256;
endpackage

// File: rtl/fifo_read_sched_rd_lat_pipe.sv
// Valid delay line matching a fixed SRAM read latency; clr empties it synchronously.
module rd_lat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in,
  output logic out
);
  logic [RD_LAT-1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (clr) vld_pipe <= '0;
    else          vld_pipe <= RD_LAT'({vld_pipe, in});
  end

  assign out = vld_pipe[RD_LAT-1];
endmodule

// File: rtl/fifo_read_sched.sv
// Burst read sequencer for the async result FIFO; sole owner of fifo_rinc.
module fifo_read_sched
  import cdc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rinc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);
  localparam logic [CNT_W-1:0] BL    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BL_M1 = CNT_W'(BURST_LEN - 1);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] iss_cnt, out_cnt;
  logic             rd_ok, enter_rd, last_iss, emit;

  assign fifo_rinc = (state == S_READ) && !fifo_empty && (iss_cnt < BL) && !abort;
  assign last_iss  = fifo_rinc && (iss_cnt == BL_M1);
  assign enter_rd  = (state == S_IDLE) && start && !abort;
  assign emit      = rd_ok && !abort;
  assign busy      = (state == S_READ) || (state == S_DRAIN);

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort),
    .in   (fifo_rinc),
    .out  (rd_ok)
  );

  // out_cnt counts at the pipe tail, so reaching BURST_LEN implies the line is empty.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)         state_nx = S_READ;
      S_READ:  if (last_iss)      state_nx = S_DRAIN;
      S_DRAIN: if (out_cnt == BL) state_nx = S_DONE;
      default:                    state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      iss_cnt   <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= emit;
      out_data  <= emit ? fifo_rdata : '0;
      done      <= (state_nx == S_DONE);
      if (abort || enter_rd) begin
        iss_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (fifo_rinc) iss_cnt <= iss_cnt + CNT_W'(1);
        if (rd_ok)     out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_read_sched.sv
// Directed bench: short bursts (BURST_LEN=4), single-word burst, full default burst.
module tb_fifo_read_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: BURST_LEN=4, RD_LAT=2
  logic       start_a = 0, abort_a = 0, empty_a = 1;
  logic [7:0] rdata_a, od_a;
  logic       rinc_a, ov_a, busy_a, done_a;
  // DUT b: defaults (256 words, RD_LAT=2)
  logic       start_b = 0, abort_b = 0, empty_b = 1;
  logic [7:0] rdata_b, od_b;
  logic       rinc_b, ov_b, busy_b, done_b;
  // DUT c: BURST_LEN=1, RD_LAT=1
  logic       start_c = 0, abort_c = 0, empty_c = 1;
  logic [7:0] rdata_c, od_c;
  logic       rinc_c, ov_c, busy_c, done_c;

  fifo_read_sched #(.DATA_W(8), .RD_LAT(2), .BURST_LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .fifo_empty(empty_a),
    .fifo_rdata(rdata_a), .fifo_rinc(rinc_a), .out_valid(ov_a), .out_data(od_a),
    .busy(busy_a), .done(done_a));
  fifo_read_sched u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .fifo_empty(empty_b),
    .fifo_rdata(rdata_b), .fifo_rinc(rinc_b), .out_valid(ov_b), .out_data(od_b),
    .busy(busy_b), .done(done_b));
  fifo_read_sched #(.DATA_W(8), .RD_LAT(1), .BURST_LEN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .fifo_empty(empty_c),
    .fifo_rdata(rdata_c), .fifo_rinc(rinc_c), .out_valid(ov_c), .out_data(od_c),
    .busy(busy_c), .done(done_c));

  // FIFO read-port models with fixed latency
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];
  logic [7:0] rp_a = 0, rp_b = 0, rp_c = 0;
  logic [7:0] dqa0, dqa1, dqb0, dqb1, dqc0;
  always @(posedge clk) begin
    dqa0 <= rinc_a ? mem_a[rp_a] : 8'h00;
    dqa1 <= dqa0;
    if (rinc_a) rp_a <= rp_a + 8'd1;
    dqb0 <= rinc_b ? mem_b[rp_b] : 8'h00;
    dqb1 <= dqb0;
    if (rinc_b) rp_b <= rp_b + 8'd1;
    dqc0 <= rinc_c ? mem_c[rp_c] : 8'h00;
    if (rinc_c) rp_c <= rp_c + 8'd1;
  end
  assign rdata_a = dqa1;
  assign rdata_b = dqb1;
  assign rdata_c = dqc0;

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic load_a(input logic [31:0] w);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      mem_a[8'(rp_a + 8'(i))] = w[8*(3-i) +: 8];
      exp_q.push_back(w[8*(3-i) +: 8]);
    end
  endtask

  // Drives one directed step per cycle on DUT a; bit c of each mask is cycle c.
  task automatic run_a(input string tag, input int ncyc, input logic [15:0] st, ab, em,
                       e_rinc, e_ov, e_busy, e_done);
    logic [7:0] ed;
    for (int c = 0; c < ncyc; c++) begin
      start_a = st[c]; abort_a = ab[c]; empty_a = em[c];
      @(negedge clk);
      ed = (e_ov[c] && exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk({tag, ".rinc"}, c, rinc_a, e_rinc[c]);
      chk({tag, ".ov"},   c, ov_a,   e_ov[c]);
      chk({tag, ".data"}, c, od_a,   ed);
      chk({tag, ".busy"}, c, busy_a, e_busy[c]);
      chk({tag, ".done"}, c, done_a, e_done[c]);
      @(posedge clk); #1;
    end
    start_a = 0; abort_a = 0; empty_a = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rinc_n, ov_n, first_ov, last_ov, done_cyc;
    logic [7:0] last_d, exp_d;

    // reset state
    #2;
    chk("rst.rinc_a", 0, rinc_a, 0);
    chk("rst.ov_a",   0, ov_a, 0);
    chk("rst.od_a",   0, od_a, 0);
    chk("rst.busy_a", 0, busy_a, 0);
    chk("rst.done_a", 0, done_a, 0);
    chk("rst.ov_b",   0, ov_b, 0);
    chk("rst.busy_c", 0, busy_c, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; empty_a = 0; empty_b = 0; empty_c = 0;
    @(posedge clk); #1;

    // basic burst: rinc 1-4, out 4-7, done 8, busy 1-7
    load_a(32'h11223344);
    run_a("basic", 10, 16'h0001, 16'h0000, 16'h0000,
          16'b0000_0000_0001_1110, 16'b0000_0000_1111_0000,
          16'b0000_0000_1111_1110, 16'b0000_0001_0000_0000);

    // empty during cycles 3-6 after two reads: rinc 1,2,7,8
    load_a(32'h55667788);
    run_a("stall", 14, 16'h0001, 16'h0000, 16'b0000_0000_0111_1000,
          16'b0000_0001_1000_0110, 16'b0000_1100_0011_0000,
          16'b0000_1111_1111_1110, 16'b0001_0000_0000_0000);

    // second start during READ ignored
    load_a(32'hA1A2A3A4);
    run_a("busy_start", 10, 16'b0000_0000_0000_0101, 16'h0000, 16'h0000,
          16'b0000_0000_0001_1110, 16'b0000_0000_1111_0000,
          16'b0000_0000_1111_1110, 16'b0000_0001_0000_0000);

    // abort one cycle after 3rd rinc: rinc forced low, only the first word appears
    load_a(32'hB1B2B3B4);
    run_a("abort", 10, 16'h0001, 16'b0000_0000_0001_0000, 16'h0000,
          16'b0000_0000_0000_1110, 16'b0000_0000_0001_0000,
          16'b0000_0000_0001_1110, 16'h0000);

    // fresh burst after abort
    load_a(32'hC1C2C3C4);
    run_a("post_abort", 10, 16'h0001, 16'h0000, 16'h0000,
          16'b0000_0000_0001_1110, 16'b0000_0000_1111_0000,
          16'b0000_0000_1111_1110, 16'b0000_0001_0000_0000);

    // start+abort together in IDLE: abort wins
    load_a(32'hD1D2D3D4);
    exp_q.delete();
    run_a("start_abort", 5, 16'h0001, 16'h0001, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // BURST_LEN=1, RD_LAT=1: rinc 1, out 3, done 4, busy 1-3
    mem_c[rp_c] = 8'h5A;
    for (int c = 0; c < 7; c++) begin
      start_c = (c == 0);
      @(negedge clk);
      chk("bl1.rinc", c, rinc_c, (c == 1));
      chk("bl1.ov",   c, ov_c,   (c == 3));
      chk("bl1.data", c, od_c,   (c == 3) ? 8'h5A : 8'h00);
      chk("bl1.busy", c, busy_c, (c >= 1 && c <= 3));
      chk("bl1.done", c, done_c, (c == 4));
      @(posedge clk); #1;
    end
    start_c = 0;

    // full default burst 0x00..0xFF
    for (int i = 0; i < 256; i++) mem_b[8'(rp_b + 8'(i))] = 8'(i);
    rinc_n = 0; ov_n = 0; first_ov = -1; last_ov = -1; done_cyc = -1; last_d = 8'h00;
    exp_d = 8'h00;
    for (int c = 0; c < 700 && done_cyc < 0; c++) begin
      start_b = (c == 0);
      @(negedge clk);
      if (rinc_b) rinc_n++;
      if (ov_b) begin
        chk("full.data", c, od_b, exp_d);
        exp_d = exp_d + 8'd1;
        ov_n++;
        if (first_ov < 0) first_ov = c;
        last_ov = c;
        last_d = od_b;
      end
      if (done_b) done_cyc = c;
      @(posedge clk); #1;
    end
    start_b = 0;
    chk("full.rinc_n",  0, rinc_n, 256);
    chk("full.ov_n",    0, ov_n, 256);
    chk("full.span",    0, last_ov - first_ov, 255);
    chk("full.last",    0, last_d, 8'hFF);
    chk("full.first",   0, first_ov, 4);
    chk("full.done_at", 0, done_cyc, last_ov + 1);

    // async reset during DRAIN: first 7 cycles of a basic burst, then reset
    load_a(32'hE1E2E3E4);
    run_a("pre_rst", 7, 16'h0001, 16'h0000, 16'h0000,
          16'b0000_0000_0001_1110, 16'b0000_0000_0111_0000,
          16'b0000_0000_0111_1110, 16'h0000);
    chk("drain.ov",   7, ov_a, 1);
    chk("drain.busy", 7, busy_a, 1);
    rst_n = 0;
    #1;
    chk("arst.ov",   7, ov_a, 0);
    chk("arst.od",   7, od_a, 0);
    chk("arst.busy", 7, busy_a, 0);
    chk("arst.done", 7, done_a, 0);
    chk("arst.rinc", 7, rinc_a, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    exp_q.delete();
    run_a("idle_after_rst", 6, 16'h0000, 16'h0000, 16'h0000,
          16'h0000, 16'h0000, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
